// File: rtl/reg_16b_in_8b_out_ser_pkg.sv
// Shared types and constants for the 16b -> 8b output serialiser and its narrowing helpers.
package reg_16b_in_8b_out_ser_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSendLo = 2'd1,
    StSendHi = 2'd2
  } state_e;

  typedef enum logic {
    ModeSat   = 1'b0,
    ModeSplit = 1'b1
  } mode_e;

  localparam logic [7:0] SAT8_MAX = 8'h7F;
  localparam logic [7:0] SAT8_MIN = 8'h80;

endpackage

// File: rtl/reg_16b_in_8b_out_ser_sat.sv
// Combinational signed narrowing of a 2*W_OUT-bit word to W_OUT bits with clipping.
module sat_16b_to_8b #(
  parameter int unsigned W_OUT = 8
) (
  input  logic [2*W_OUT-1:0] x_i,
  output logic [W_OUT-1:0]   c_o,
  output logic               ovf_o
);

  localparam int unsigned W_IN = 2 * W_OUT;

  localparam logic [W_OUT-1:0] SatMax = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] SatMin = {1'b1, {(W_OUT-1){1'b0}}};

  // The value fits iff all bits from the output sign bit upward agree.
  logic [W_OUT:0] upper;

  always_comb begin
    upper = x_i[W_IN-1:W_OUT-1];
    ovf_o = ~((&upper) | (~|upper));
    if (!ovf_o) begin
      c_o = x_i[W_OUT-1:0];
    end else if (x_i[W_IN-1]) begin
      c_o = SatMin;
    end else begin
      c_o = SatMax;
    end
  end

endmodule

// File: rtl/reg_16b_in_8b_out_ser.sv
// Output-boundary register: narrows a 16-bit word onto an 8-bit VALID/OUT_RDY bus,
// either as one saturated byte (SAT) or as low byte then high byte (SPLIT).
module reg_16b_in_8b_out_ser
  import reg_16b_in_8b_out_ser_pkg::*;
#(
  parameter int unsigned W_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*W_OUT-1:0]   X,
  input  logic                 LX,
  input  logic                 MODE,
  output logic                 RDY,
  output logic [W_OUT-1:0]     C,
  output logic                 VALID,
  input  logic                 OUT_RDY,
  output logic                 LAST,
  output logic                 OVF
);

  localparam int unsigned W_IN = 2 * W_OUT;

  state_e           state_q;
  mode_e            mode_q;
  logic [W_OUT-1:0] hold_hi_q;
  logic [W_OUT-1:0] c_q;
  logic             valid_q;
  logic             last_q;
  logic             ovf_q;

  logic [W_OUT-1:0] sat_c;
  logic             sat_ovf;
  logic             accept;
  logic             xfer;
  mode_e            mode_in;

  sat_16b_to_8b #(
    .W_OUT (W_OUT)
  ) u_sat (
    .x_i   (X),
    .c_o   (sat_c),
    .ovf_o (sat_ovf)
  );

  assign mode_in = mode_e'(MODE);
  assign xfer    = valid_q & OUT_RDY;
  // Final-byte handoff frees the slot on the same edge, so words stream without a bubble.
  assign RDY     = (state_q == StIdle) | (valid_q & last_q & OUT_RDY);
  assign accept  = LX & RDY;

  // The low byte goes straight to C at accept, so only the high byte needs holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= ModeSat;
      hold_hi_q <= '0;
      c_q       <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      state_q   <= StSendLo;
      mode_q    <= mode_in;
      hold_hi_q <= X[W_IN-1:W_OUT];
      valid_q   <= 1'b1;
      if (mode_in == ModeSplit) begin
        c_q    <= X[W_OUT-1:0];
        last_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        c_q    <= sat_c;
        last_q <= 1'b1;
        ovf_q  <= sat_ovf;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
        end
        StSendLo: begin
          if (xfer) begin
            if (mode_q == ModeSplit) begin
              state_q <= StSendHi;
              c_q     <= hold_hi_q;
              last_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              ovf_q   <= 1'b0;
            end
          end
        end
        StSendHi: begin
          if (xfer) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  assign C     = c_q;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_reg_16b_in_8b_out_ser.sv
// Directed self-checking bench for reg_16b_in_8b_out_ser.
module tb_reg_16b_in_8b_out_ser;
  import reg_16b_in_8b_out_ser_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] X;
  logic        LX;
  logic        MODE;
  logic        RDY;
  logic [7:0]  C;
  logic        VALID;
  logic        OUT_RDY;
  logic        LAST;
  logic        OVF;

  int unsigned n_cmp;
  int unsigned n_err;

  reg_16b_in_8b_out_ser #(
    .W_OUT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .X       (X),
    .LX      (LX),
    .MODE    (MODE),
    .RDY     (RDY),
    .C       (C),
    .VALID   (VALID),
    .OUT_RDY (OUT_RDY),
    .LAST    (LAST),
    .OVF     (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_byte(input string tag, input logic [7:0] c, input logic v,
                            input logic l, input logic o);
    check_eq({tag, ".C"}, {8'h00, C}, {8'h00, c});
    check_eq({tag, ".VALID"}, {15'h0, VALID}, {15'h0, v});
    check_eq({tag, ".LAST"}, {15'h0, LAST}, {15'h0, l});
    check_eq({tag, ".OVF"}, {15'h0, OVF}, {15'h0, o});
  endtask

  task automatic sat_one(input string tag, input logic [15:0] x, input logic [7:0] c,
                         input logic o);
    X = x; MODE = 1'b0; LX = 1'b1; OUT_RDY = 1'b1;
    step();
    LX = 1'b0; X = 16'hDEAD;
    check_byte(tag, c, 1'b1, 1'b1, o);
    step();
    check_eq({tag, ".idle_valid"}, {15'h0, VALID}, 16'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; X = '0; LX = 1'b0; MODE = 1'b0; OUT_RDY = 1'b0;
    step();
    step();
    check_byte("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("reset.RDY", {15'h0, RDY}, 16'h1);
    rst_n = 1'b1;
    step();

    // Single SAT byte in range
    sat_one("sat42", 16'h0042, 8'h42, 1'b0);
    check_eq("sat42.RDY", {15'h0, RDY}, 16'h1);

    // Clipping boundaries
    sat_one("satpos", 16'h0200, SAT8_MAX, 1'b1);
    sat_one("satneg", 16'hFE00, SAT8_MIN, 1'b1);
    sat_one("satm128", 16'hFF80, 8'h80, 1'b0);
    sat_one("sat127", 16'h007F, 8'h7F, 1'b0);
    sat_one("sat128", 16'h0080, SAT8_MAX, 1'b1);

    // SPLIT streaming
    X = 16'hA55A; MODE = 1'b1; LX = 1'b1; OUT_RDY = 1'b1;
    step();
    LX = 1'b0; X = '0; MODE = 1'b0;
    check_byte("splitlo", 8'h5A, 1'b1, 1'b0, 1'b0);
    step();
    check_byte("splithi", 8'hA5, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("split.idle_valid", {15'h0, VALID}, 16'h0);

    // Stall on low byte; LX meanwhile ignored
    X = 16'h1234; MODE = 1'b1; LX = 1'b1; OUT_RDY = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      X = 16'hFFFF; MODE = 1'b0; LX = 1'b1;
      #1;
      check_eq("stall.RDY", {15'h0, RDY}, 16'h0);
      step();
      check_byte("stall", 8'h34, 1'b1, 1'b0, 1'b0);
    end
    LX = 1'b0; OUT_RDY = 1'b1;
    step();
    check_byte("stallhi", 8'h12, 1'b1, 1'b1, 1'b0);
    X = 16'h0005; MODE = 1'b0; LX = 1'b1;
    #1;
    check_eq("stallnext.RDY", {15'h0, RDY}, 16'h1);
    step();
    LX = 1'b0;
    check_byte("stallnext", 8'h05, 1'b1, 1'b1, 1'b0);
    step();
    check_eq("stallnext.idle_valid", {15'h0, VALID}, 16'h0);

    // Back-to-back SAT words, no bubble
    MODE = 1'b0; LX = 1'b1; OUT_RDY = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      X = 16'(i);
      step();
      check_byte("b2b", 8'(i), 1'b1, 1'b1, 1'b0);
    end
    LX = 1'b0;
    step();
    check_eq("b2b.idle_valid", {15'h0, VALID}, 16'h0);

    // Reset mid-SPLIT after the low byte
    X = 16'hBEEF; MODE = 1'b1; LX = 1'b1; OUT_RDY = 1'b0;
    step();
    LX = 1'b0;
    check_byte("rstmid.lo", 8'hEF, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_byte("rstmid.async", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1; OUT_RDY = 1'b1;
    #1;
    check_eq("rstmid.RDY", {15'h0, RDY}, 16'h1);
    step();
    check_byte("rstmid.nohi1", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check_byte("rstmid.nohi2", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
